// File: rtl/sram_ctrl.sv
// sram_ctrl: 32-bit word controller for a 16-bit asynchronous cellular SRAM.
// Serves the cache instruction port, the cache data port and the VGA read port.
// Each word is split into two halfword accesses, high half first.
// Optional feature: define SRAM_PAGE_MODE_EN to shorten the second halfword of reads
// to PAGE_CYCLES (page-mode read).
module sram_ctrl #(
  parameter int unsigned WAIT_CYCLES = 4,
  parameter int unsigned PAGE_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ie,
  input  logic        de,
  input  logic [31:0] iaddr,
  input  logic [31:0] daddr,
  input  logic        drw,
  input  logic [31:0] din,
  output logic [31:0] iout,
  output logic [31:0] dout,
  output logic        rdy,
  input  logic [31:0] vga_addr,
  input  logic        vga_read,
  output logic [31:0] vga_data,
  output logic        vga_rdy,
  output logic        sram_clk,
  output logic        sram_adv,
  output logic        sram_cre,
  output logic        sram_ce,
  output logic        sram_oe,
  output logic        sram_we,
  output logic        sram_lb,
  output logic        sram_ub,
  output logic [22:0] sram_addr,
  inout  wire  [15:0] sram_data
);

  typedef enum logic [2:0] {StIdle, StVga, StData, StInst, StDone} state_e;

  localparam int unsigned CntW = $clog2(WAIT_CYCLES + PAGE_CYCLES + 1);
  localparam logic [CntW-1:0] LastWait = CntW'(WAIT_CYCLES - 1);
`ifdef SRAM_PAGE_MODE_EN
  localparam logic [CntW-1:0] LastPage = CntW'(PAGE_CYCLES - 1);
`endif

  state_e          state_q, state_d;
  logic            half_q;
  logic [CntW-1:0] cnt_q;
  logic            ie_q, drw_q, vga_owed_q, vga_rdy_q;
  logic [21:0]     iaddr_q, daddr_q, vaddr_q;
  logic [31:0]     din_q;
  logic [15:0]     hi_q;
  logic [31:0]     iout_q, dout_q, vga_data_q;

  logic            access, is_write, last_cycle, word_done;
  logic            vga_req, accept, vga_start;
  logic [CntW-1:0] last_cnt;
  logic [21:0]     cur_addr;
  logic [15:0]     wdata;
  logic            unused_bits;

  // Only word-address bits [23:2] reach the SRAM.
  assign unused_bits = ^{iaddr[31:24], iaddr[1:0], daddr[31:24], daddr[1:0],
                         vga_addr[31:24], vga_addr[1:0], (PAGE_CYCLES != 32'd0)};

  // Requester still sees vga_read high during its vga_rdy cycle; don't re-serve it.
  assign vga_req = vga_read && !vga_rdy_q;

  // Datapath decode for the halfword access in progress.
  always_comb begin
    access   = (state_q == StVga) || (state_q == StData) || (state_q == StInst);
    is_write = (state_q == StData) && drw_q;
    case (state_q)
      StVga:   cur_addr = vaddr_q;
      StData:  cur_addr = daddr_q;
      default: cur_addr = iaddr_q;
    endcase
`ifdef SRAM_PAGE_MODE_EN
    last_cnt = (half_q && !is_write) ? LastPage : LastWait;
`else
    last_cnt = LastWait;
`endif
    last_cycle = access && (cnt_q == last_cnt);
    word_done  = last_cycle && half_q;
    wdata      = half_q ? din_q[15:0] : din_q[31:16];
  end

  assign sram_clk  = 1'b0;
  assign sram_adv  = 1'b0;
  assign sram_cre  = 1'b0;
  assign sram_ce   = !access;
  assign sram_lb   = !access;
  assign sram_ub   = !access;
  assign sram_oe   = !(access && !is_write);
  // Final write cycle raises we while data is still driven (hold time).
  assign sram_we   = !(is_write && (cnt_q != LastWait));
  assign sram_addr = access ? {cur_addr, half_q} : 23'd0;
  assign sram_data = is_write ? wdata : 16'hzzzz;

  assign rdy      = (state_q == StDone);
  assign vga_rdy  = vga_rdy_q;
  assign iout     = iout_q;
  assign dout     = dout_q;
  assign vga_data = vga_data_q;

  // Arbitration and word sequencing.
  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle: begin
        if (vga_owed_q || (vga_req && !ie && !de)) state_d = StVga;
        else if (de)                                state_d = StData;
        else if (ie)                                state_d = StInst;
      end
      StVga:   if (word_done) state_d = StIdle;
      StData:  if (word_done) state_d = ie_q ? StInst : StDone;
      StInst:  if (word_done) state_d = StDone;
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
    accept    = (state_q == StIdle) && ((state_d == StData) || (state_d == StInst));
    vga_start = (state_q == StIdle) && (state_d == StVga);
  end

  // State, halfword and wait counters.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= StIdle;
      half_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      if (!access) begin
        half_q <= 1'b0;
        cnt_q  <= '0;
      end else if (last_cycle) begin
        half_q <= !half_q;
        cnt_q  <= '0;
      end else begin
        cnt_q <= cnt_q + CntW'(1);
      end
    end
  end

  // Request latches; CPU inputs are frozen at acceptance until rdy.
  always_ff @(posedge clk) begin
    if (!rst) begin
      ie_q       <= 1'b0;
      drw_q      <= 1'b0;
      iaddr_q    <= '0;
      daddr_q    <= '0;
      din_q      <= '0;
      vaddr_q    <= '0;
      vga_owed_q <= 1'b0;
    end else begin
      if (accept) begin
        ie_q       <= ie;
        drw_q      <= drw;
        iaddr_q    <= iaddr[23:2];
        daddr_q    <= daddr[23:2];
        din_q      <= din;
        vga_owed_q <= vga_req;
      end
      if (vga_start) begin
        vaddr_q    <= vga_addr[23:2];
        vga_owed_q <= 1'b0;
      end
    end
  end

  // Read capture; results only move when the second halfword completes.
  always_ff @(posedge clk) begin
    if (!rst) begin
      hi_q       <= '0;
      iout_q     <= '0;
      dout_q     <= '0;
      vga_data_q <= '0;
      vga_rdy_q  <= 1'b0;
    end else begin
      vga_rdy_q <= (state_q == StVga) && word_done;
      if (last_cycle && !half_q && !is_write) hi_q <= sram_data;
      if (word_done && !is_write) begin
        case (state_q)
          StVga:   vga_data_q <= {hi_q, sram_data};
          StData:  dout_q     <= {hi_q, sram_data};
          default: iout_q     <= {hi_q, sram_data};
        endcase
      end
    end
  end

endmodule

// File: tb/tb_sram_ctrl.sv
// tb_sram_ctrl: self-checking bench for sram_ctrl with a halfword SRAM model and a
// word-level reference memory.
module tb_sram_ctrl;
  localparam int unsigned W = 4;

  logic        clk;
  logic        rst;
  logic        ie, de, drw, vga_read;
  logic [31:0] iaddr, daddr, din, vga_addr;
  logic [31:0] iout, dout, vga_data;
  logic        rdy, vga_rdy;
  logic        sram_clk, sram_adv, sram_cre;
  logic        sram_ce, sram_oe, sram_we, sram_lb, sram_ub;
  logic [22:0] sram_addr;
  wire  [15:0] sram_data;

  logic [15:0] sram_mem [4096];
  logic [31:0] ref_mem [2048];
  logic        load_req;
  logic [31:0] iout_exp, dout_exp;
  int          checks, errors;

  sram_ctrl #(.WAIT_CYCLES(W), .PAGE_CYCLES(2)) dut (
    .clk(clk), .rst(rst), .ie(ie), .de(de), .iaddr(iaddr), .daddr(daddr), .drw(drw),
    .din(din), .iout(iout), .dout(dout), .rdy(rdy), .vga_addr(vga_addr),
    .vga_read(vga_read), .vga_data(vga_data), .vga_rdy(vga_rdy), .sram_clk(sram_clk),
    .sram_adv(sram_adv), .sram_cre(sram_cre), .sram_ce(sram_ce), .sram_oe(sram_oe),
    .sram_we(sram_we), .sram_lb(sram_lb), .sram_ub(sram_ub), .sram_addr(sram_addr),
    .sram_data(sram_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Asynchronous SRAM model: drives on read, stores while ce and we are low.
  assign sram_data = (!sram_ce && !sram_oe && sram_we) ? sram_mem[sram_addr[11:0]] : 16'hzzzz;
  always @(posedge clk) begin
    if (load_req) begin
      for (int i = 0; i < 2048; i++) begin
        sram_mem[2*i]   <= ref_mem[i][31:16];
        sram_mem[2*i+1] <= ref_mem[i][15:0];
      end
    end else if (!sram_ce && !sram_we) begin
      sram_mem[sram_addr[11:0]] <= sram_data;
    end
  end

  // Wait for rdy; lat = cycles after the request cycle, -1 on timeout.
  task automatic wait_rdy(input int budget, output int lat, output int we_low);
    lat = -1;
    we_low = 0;
    for (int k = 1; k <= budget; k++) begin
      @(posedge clk); @(negedge clk);
      if (!sram_we) we_low++;
      if (rdy) begin
        lat = k;
        break;
      end
    end
  endtask

  task automatic idle_cycle();
    @(posedge clk); @(negedge clk);
    checks++;
    if (rdy !== 1'b0) begin errors++; $display("FAIL rdy_pulse got %b want 0", rdy); end
  endtask

  task automatic test_reset();
    repeat (3) begin @(posedge clk); @(negedge clk); end
    checks++; if (rdy !== 1'b0) begin errors++; $display("FAIL rst_rdy got %b want 0", rdy); end
    checks++; if (vga_rdy !== 1'b0) begin errors++; $display("FAIL rst_vga_rdy got %b want 0", vga_rdy); end
    checks++; if (iout !== 32'h0) begin errors++; $display("FAIL rst_iout got %h want 0", iout); end
    checks++; if (dout !== 32'h0) begin errors++; $display("FAIL rst_dout got %h want 0", dout); end
    checks++; if (vga_data !== 32'h0) begin errors++; $display("FAIL rst_vga_data got %h want 0", vga_data); end
    checks++;
    if ({sram_ce, sram_oe, sram_we, sram_lb, sram_ub} !== 5'b11111) begin
      errors++;
      $display("FAIL rst_strobes got %b want 11111", {sram_ce, sram_oe, sram_we, sram_lb, sram_ub});
    end
    checks++;
    if ({sram_clk, sram_adv, sram_cre} !== 3'b000) begin
      errors++; $display("FAIL rst_ties got %b want 000", {sram_clk, sram_adv, sram_cre});
    end
    checks++; if (sram_addr !== 23'h0) begin errors++; $display("FAIL rst_addr got %h want 0", sram_addr); end
    rst = 1'b1;
    @(posedge clk); @(negedge clk);
  endtask

  task automatic test_read();
    int lat, we_low;
    daddr = 32'hA500_0201; drw = 1'b0; de = 1'b1;
    dout_exp = ref_mem[daddr[12:2]];
    wait_rdy(40, lat, we_low);
    de = 1'b0;
    checks++; if (lat != int'(2*W+1)) begin errors++; $display("FAIL read_lat got %0d want %0d", lat, 2*W+1); end
    checks++; if (dout !== 32'hDEADBEEF) begin errors++; $display("FAIL read_dout got %h want deadbeef", dout); end
    checks++; if (iout !== iout_exp) begin errors++; $display("FAIL read_iout got %h want %h", iout, iout_exp); end
    checks++; if (we_low != 0) begin errors++; $display("FAIL read_we got %0d want 0", we_low); end
    idle_cycle();
  endtask

  task automatic test_write();
    int lat, we_low;
    daddr = 32'h0000_0204; drw = 1'b1; din = 32'h12345678; de = 1'b1;
    ref_mem[daddr[12:2]] = din;
    wait_rdy(40, lat, we_low);
    de = 1'b0;
    checks++; if (lat != int'(2*W+1)) begin errors++; $display("FAIL write_lat got %0d want %0d", lat, 2*W+1); end
    checks++; if (we_low != int'(2*(W-1))) begin errors++; $display("FAIL write_we got %0d want %0d", we_low, 2*(W-1)); end
    checks++; if (dout !== dout_exp) begin errors++; $display("FAIL write_dout got %h want %h", dout, dout_exp); end
    checks++; if (sram_mem[12'h102] !== 16'h1234) begin errors++; $display("FAIL write_hi got %h want 1234", sram_mem[12'h102]); end
    checks++; if (sram_mem[12'h103] !== 16'h5678) begin errors++; $display("FAIL write_lo got %h want 5678", sram_mem[12'h103]); end
    idle_cycle();
  endtask

  task automatic test_back_to_back();
    int lat, we_low;
    daddr = 32'h0000_0200; iaddr = 32'h0000_0204; drw = 1'b0; de = 1'b1; ie = 1'b1;
    dout_exp = ref_mem[daddr[12:2]];
    iout_exp = ref_mem[iaddr[12:2]];
    @(posedge clk); @(negedge clk);
    checks++; if (sram_addr !== 23'h000100) begin errors++; $display("FAIL b2b_first got %h want 000100", sram_addr); end
    wait_rdy(60, lat, we_low);
    de = 1'b0; ie = 1'b0;
    checks++; if (lat + 1 != int'(4*W+1)) begin errors++; $display("FAIL b2b_lat got %0d want %0d", lat + 1, 4*W+1); end
    checks++; if (dout !== dout_exp) begin errors++; $display("FAIL b2b_dout got %h want %h", dout, dout_exp); end
    checks++; if (iout !== iout_exp) begin errors++; $display("FAIL b2b_iout got %h want %h", iout, iout_exp); end
    idle_cycle();
  endtask

  task automatic test_vga_owed();
    int lat, we_low, cyc, vga_at, rdy_at, vcnt;
    logic [31:0] vexp;
    vga_addr = 32'h7700_0300; vexp = ref_mem[vga_addr[12:2]];
    daddr = 32'h0000_0200; drw = 1'b0; de = 1'b1; vga_read = 1'b1;
    dout_exp = ref_mem[daddr[12:2]];
    wait_rdy(40, lat, we_low);
    checks++; if (lat != int'(2*W+1)) begin errors++; $display("FAIL vga_first_lat got %0d want %0d", lat, 2*W+1); end
    checks++; if (dout !== dout_exp) begin errors++; $display("FAIL vga_first_dout got %h want %h", dout, dout_exp); end
    daddr = 32'h0000_0404;
    dout_exp = ref_mem[daddr[12:2]];
    vga_at = -1; rdy_at = -1; vcnt = 0;
    for (cyc = 1; cyc <= 60; cyc++) begin
      @(posedge clk); @(negedge clk);
      if (vga_rdy) begin
        vcnt++; vga_at = cyc; vga_read = 1'b0;
        checks++; if (vga_data !== vexp) begin errors++; $display("FAIL vga_data got %h want %h", vga_data, vexp); end
      end
      if (rdy) begin rdy_at = cyc; break; end
    end
    de = 1'b0;
    checks++; if (vga_at != int'(2*W+2)) begin errors++; $display("FAIL vga_rdy_at got %0d want %0d", vga_at, 2*W+2); end
    checks++; if (rdy_at != int'(4*W+3)) begin errors++; $display("FAIL vga_second_rdy got %0d want %0d", rdy_at, 4*W+3); end
    checks++; if (vcnt != 1) begin errors++; $display("FAIL vga_pulses got %0d want 1", vcnt); end
    checks++; if (dout !== dout_exp) begin errors++; $display("FAIL vga_second_dout got %h want %h", dout, dout_exp); end
    vga_read = 1'b0;
    idle_cycle();
  endtask

  task automatic test_reset_abort();
    int lat, we_low, rcnt;
    daddr = 32'h0000_0208; drw = 1'b1; din = 32'hCAFEF00D; de = 1'b1;
    repeat (5) begin @(posedge clk); @(negedge clk); end
    rst = 1'b0; de = 1'b0;
    @(posedge clk); @(negedge clk);
    checks++;
    if ({sram_ce, sram_oe, sram_we} !== 3'b111) begin
      errors++; $display("FAIL abort_strobes got %b want 111", {sram_ce, sram_oe, sram_we});
    end
    checks++; if (sram_addr !== 23'h0) begin errors++; $display("FAIL abort_addr got %h want 0", sram_addr); end
    checks++; if (dout !== 32'h0) begin errors++; $display("FAIL abort_dout got %h want 0", dout); end
    rst = 1'b1;
    dout_exp = 32'h0; iout_exp = 32'h0;
    // The aborted write is never read back, so its partial contents don't matter.
    rcnt = 0;
    repeat (12) begin
      @(posedge clk); @(negedge clk);
      if (rdy) rcnt++;
    end
    checks++; if (rcnt != 0) begin errors++; $display("FAIL abort_rdy got %0d want 0", rcnt); end
    daddr = 32'h0000_0200; drw = 1'b0; de = 1'b1;
    dout_exp = ref_mem[daddr[12:2]];
    wait_rdy(40, lat, we_low);
    de = 1'b0;
    checks++; if (lat != int'(2*W+1)) begin errors++; $display("FAIL abort_read_lat got %0d want %0d", lat, 2*W+1); end
    checks++; if (dout !== dout_exp) begin errors++; $display("FAIL abort_read_dout got %h want %h", dout, dout_exp); end
    idle_cycle();
  endtask

  function automatic logic [31:0] pool_addr();
    logic [31:0] a;
    a = ($urandom & 32'hFF00_0003) | (32'($urandom_range(32'h40, 32'h4F)) << 2);
    return a;
  endfunction

  task automatic test_random();
    int lat, we_low, sel, exp_lat;
    for (int n = 0; n < 24; n++) begin
      sel = int'($urandom_range(1, 3));
      de = sel[0]; ie = sel[1];
      drw = 1'($urandom); daddr = pool_addr(); iaddr = pool_addr(); din = $urandom;
      exp_lat = 1 + (de ? int'(2*W) : 0) + (ie ? int'(2*W) : 0);
      if (de && drw) ref_mem[daddr[12:2]] = din;
      else if (de) dout_exp = ref_mem[daddr[12:2]];
      if (ie) iout_exp = ref_mem[iaddr[12:2]];
      @(posedge clk); @(negedge clk);
      // Inputs other than ie/de move after acceptance and must be ignored.
      drw = 1'($urandom); daddr = $urandom; iaddr = $urandom; din = $urandom;
      wait_rdy(60, lat, we_low);
      de = 1'b0; ie = 1'b0;
      checks++; if (lat + 1 != exp_lat) begin errors++; $display("FAIL rnd%0d_lat got %0d want %0d", n, lat + 1, exp_lat); end
      checks++; if (dout !== dout_exp) begin errors++; $display("FAIL rnd%0d_dout got %h want %h", n, dout, dout_exp); end
      checks++; if (iout !== iout_exp) begin errors++; $display("FAIL rnd%0d_iout got %h want %h", n, iout, iout_exp); end
      idle_cycle();
    end
  endtask

  initial begin
    checks = 0; errors = 0;
    rst = 1'b0; ie = 1'b0; de = 1'b0; drw = 1'b0; vga_read = 1'b0;
    iaddr = '0; daddr = '0; din = '0; vga_addr = '0;
    iout_exp = 32'h0; dout_exp = 32'h0;
    for (int i = 0; i < 2048; i++) ref_mem[i] = $urandom;
    ref_mem[11'h080] = 32'hDEADBEEF;
    load_req = 1'b1;
    @(posedge clk); @(negedge clk);
    load_req = 1'b0;
    test_reset();
    test_read();
    test_write();
    test_back_to_back();
    test_vga_owed();
    test_reset_abort();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
